// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests one word at a time from instruction memory
// and holds it for the decoder until consumed or flushed by a branch redirect.
//
// state | meaning
// FETCH | read request outstanding at pc, waiting for imem_ack
// FULL  | instruction held in instr, waiting for decoder to consume
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [15:0] pc_out
);

   typedef enum logic {
      FETCH = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state;
   logic [15:0] pc;

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= 16'h0000;
         pc_out      <= 16'h0000;
         instr_valid <= 1'b0;
      end else if (br_taken) begin
         // redirect wins over ack and stall; a coinciding ack is dropped
         state       <= FETCH;
         pc          <= br_target;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_data;
                  pc_out      <= pc;
                  pc          <= pc + 16'd1;
                  instr_valid <= 1'b1;
                  state       <= FULL;
               end
            end
            FULL: begin
               if (!stall) begin
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle-level model of the fetch stage plus a
// scoreboard of fetched words checked when the decoder consumes them.
module tb_instruction_fetch;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        stall;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc_out;

   instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_out      (pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] m_pc    = RESET_PC;
   logic        m_full  = 1'b0;
   logic [15:0] m_instr = 16'h0000;
   logic [15:0] m_pcout = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] dfn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // Called at a falling edge: check current outputs, drive this cycle's inputs,
   // advance the model, then wait for the next falling edge.
   task automatic cycle(input logic ack, input logic [15:0] data, input logic stl,
                        input logic br, input logic [15:0] tgt);
      exp_t e;
      chk("imem_req", imem_req, !m_full);
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", instr_valid, m_full);
      chk("instr", instr, m_instr);
      chk("pc_out", pc_out, m_pcout);
      imem_ack  = ack;
      imem_data = data;
      stall     = stl;
      br_taken  = br;
      br_target = tgt;
      if (m_full && (br || !stl)) begin
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else begin
            e = sb.pop_front();
            if (!br) begin
               chk("consume_instr", instr, e.data);
               chk("consume_pc", pc_out, e.pc);
            end
         end
      end
      if (br) begin
         m_pc   = tgt;
         m_full = 1'b0;
      end else if (!m_full && ack) begin
         e.pc   = m_pc;
         e.data = data;
         sb.push_back(e);
         m_instr = data;
         m_pcout = m_pc;
         m_pc    = m_pc + 16'd1;
         m_full  = 1'b1;
      end else if (m_full && !stl) begin
         m_full = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic fetch_ack(input logic stl);
      cycle(1'b1, dfn(m_pc), stl, 1'b0, 16'h0000);
   endtask

   task automatic idle(input logic ack, input logic stl);
      cycle(ack, dfn(m_pc), stl, 1'b0, 16'h0000);
   endtask

   task automatic branch(input logic ack, input logic stl, input logic [15:0] tgt);
      cycle(ack, dfn(m_pc), stl, 1'b1, tgt);
   endtask

   task automatic reset_pulse();
      imem_ack = 1'b0;
      stall    = 1'b0;
      br_taken = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_imem_req", imem_req, 1);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_pc_out", pc_out, 16'h0000);
      m_pc    = RESET_PC;
      m_full  = 1'b0;
      m_instr = 16'h0000;
      m_pcout = 16'h0000;
      sb.delete();
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      imem_ack  = 1'b0;
      imem_data = 16'h0000;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 16'h0000;
      repeat (2) @(negedge clk);
      chk("reset_req", imem_req, 1);
      chk("reset_addr", imem_addr, RESET_PC);
      chk("reset_valid", instr_valid, 0);
      chk("reset_instr", instr, 16'h0000);
      chk("reset_pc_out", pc_out, 16'h0000);
      rst_n = 1'b1;

      // streaming: ack every request immediately, never stall
      repeat (8) fetch_ack(1'b0);

      // hold under stall with memory acks that must be ignored
      cycle(1'b1, 16'hB123, 1'b0, 1'b0, 16'h0000);
      repeat (5) idle(1'b1, 1'b1);
      chk("stall_hold_instr", instr, 16'hB123);
      idle(1'b0, 1'b0);

      // PC wrap at the top of the address space
      branch(1'b0, 1'b0, 16'hFFFF);
      idle(1'b0, 1'b0);
      fetch_ack(1'b0);
      chk("wrap_pc_out", pc_out, 16'hFFFF);
      chk("wrap_next_addr", imem_addr, 16'h0000);
      idle(1'b0, 1'b0);

      // ack coinciding with branch is discarded
      branch(1'b1, 1'b0, 16'h0040);
      chk("br_ack_addr", imem_addr, 16'h0040);
      fetch_ack(1'b0);
      idle(1'b0, 1'b0);

      // branch while full and stalled flushes the held instruction
      fetch_ack(1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      branch(1'b0, 1'b1, 16'h0123);
      chk("br_full_valid", instr_valid, 0);
      fetch_ack(1'b0);
      idle(1'b0, 1'b0);

      // reset during a wait at 0x0010
      branch(1'b0, 1'b0, 16'h0010);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      reset_pulse();
      fetch_ack(1'b0);
      idle(1'b0, 1'b0);

      // reset during a stall
      fetch_ack(1'b1);
      idle(1'b0, 1'b1);
      reset_pulse();
      idle(1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 200; i++) begin
         logic        a, s, b;
         logic [15:0] t;
         a = ($urandom_range(0, 2) != 0);
         s = ($urandom_range(0, 2) == 0);
         b = ($urandom_range(0, 9) == 0);
         t = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         cycle(a, 16'($urandom), s, b, t);
      end
      idle(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 IMEM_REQ  output  1  instruction memory read request.
REQ-005 IMEM_ADDR  output  16  word address of requested instruction.
REQ-006 IMEM_ACK  input  1  IMEM_DATA valid this cycle for the current request.
REQ-007 IMEM_DATA  input  16  instruction word returned by memory.
REQ-008 STALL  input  1  downstream decoder cannot accept the held instruction.
REQ-009 BR_TAKEN  input  1  redirect fetch to BR_TARGET.
REQ-010 BR_TARGET  input  16  redirect word address.
REQ-011 INSTR  output  16  instruction word presented to the decoder A input.
REQ-012 INSTR_VALID  output  1  INSTR holds a valid, unconsumed instruction.
REQ-013 PC_OUT  output  16  word address INSTR was fetched from.

Function
REQ-014 The block SHALL implement two states: FETCH (request outstanding) and FULL (instruction held).
REQ-015 The block SHALL hold an internal 16-bit PC; IMEM_ADDR SHALL equal PC at all times.
REQ-016 IMEM_REQ SHALL be 1 exactly when state is FETCH; IMEM_ADDR SHALL be stable while IMEM_REQ is 1, unless redirected.
REQ-017 In FETCH with IMEM_ACK=1 and BR_TAKEN=0, the block SHALL capture IMEM_DATA into INSTR, set PC_OUT<=PC, set PC<=PC+1, set INSTR_VALID<=1, and move to FULL.
REQ-018 PC increment SHALL be modulo 2^16: 16'hFFFF + 1 = 16'h0000.
REQ-019 In FETCH with IMEM_ACK=0, state, PC and outputs SHALL hold; wait length is unbounded.
REQ-020 An instruction SHALL be consumed on a cycle where INSTR_VALID=1 and STALL=0; in FULL on consumption the block SHALL clear INSTR_VALID and move to FETCH.
REQ-021 In FULL with STALL=1, INSTR, PC_OUT and INSTR_VALID SHALL hold unchanged.
REQ-022 IMEM_ACK in FULL SHALL be ignored.
REQ-023 BR_TAKEN=1 in any state SHALL, next edge: PC<=BR_TARGET, INSTR_VALID<=0, state<=FETCH; it SHALL take priority over STALL and IMEM_ACK.
REQ-024 An IMEM_ACK coinciding with BR_TAKEN SHALL be discarded (INSTR not loaded, PC not incremented).
REQ-025 INSTR and PC_OUT SHALL retain their last values when INSTR_VALID=0; consumers SHALL qualify by INSTR_VALID.
REQ-026 Minimum issue latency: IMEM_ACK on cycle N gives INSTR_VALID=1 on cycle N+1; a fetch-consume loop with ACK in the first request cycle yields one instruction per 2 cycles.

Reset
REQ-027 On RSTN=0, asynchronously: PC=RESET_PC, state=FETCH, INSTR=16'h0000, PC_OUT=16'h0000, INSTR_VALID=0; hence IMEM_REQ=1 with IMEM_ADDR=RESET_PC.
REQ-028 Reset asserted mid-wait or mid-stall SHALL abandon the request and held instruction; after release, fetching SHALL restart at RESET_PC.

Verification
REQ-029 Reset release, memory acks every request immediately, STALL=0 -> IMEM_ADDR sequence 0,1,2,...; INSTR_VALID pulses every other cycle with PC_OUT 0,1,2.
REQ-030 IMEM_DATA=16'hB123 acked, then STALL=1 for 5 cycles -> INSTR=16'hB123, PC_OUT constant, INSTR_VALID=1, IMEM_REQ=0 throughout stall.
REQ-031 PC=16'hFFFF, ack -> PC_OUT=16'hFFFF, next IMEM_ADDR=16'h0000.
REQ-032 BR_TAKEN=1, BR_TARGET=16'h0040 coinciding with IMEM_ACK in FETCH -> INSTR_VALID=0, INSTR unchanged, next IMEM_ADDR=16'h0040.
REQ-033 BR_TAKEN=1 while FULL with STALL=1 -> INSTR_VALID drops next cycle, IMEM_REQ=1 at BR_TARGET.
REQ-034 RSTN pulsed low during a 3-cycle IMEM_ACK wait at 16'h0010 -> outputs reset immediately; after release IMEM_ADDR=RESET_PC.
